// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU definitions: function selects, flag bit positions and the
// multiplier sequencer state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [4:0] FS_A32   = 5'b10000;
  localparam logic [4:0] FS_ADD32 = 5'b10100;
  localparam logic [4:0] FS_LSL32 = 5'b11011;

  localparam int unsigned FLAG_ZERO     = 3;
  localparam int unsigned FLAG_CARRY    = 2;
  localparam int unsigned FLAG_NEGATIVE = 1;
  localparam int unsigned FLAG_OVERFLOW = 0;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAdd,
    StShl,
    StDone
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/result handshake plus the ALU drive/return path of the multiplier.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 Start;
  logic                 Ready;
  logic [WIDTH-1:0]     MulA;
  logic [WIDTH-1:0]     MulB;
  logic                 Busy;
  logic                 ResultValid;
  logic                 ResultReady;
  logic [2*WIDTH-1:0]   Product;
  logic [31:0]          AluA;
  logic [31:0]          AluB;
  logic [4:0]           AluFunSel;
  logic                 AluWF;
  logic [31:0]          AluOut;

  modport master (
    output Start, MulA, MulB, ResultReady, AluOut,
    input  Ready, Busy, ResultValid, Product, AluA, AluB, AluFunSel, AluWF
  );

  modport slave (
    input  Start, MulA, MulB, ResultReady, AluOut,
    output Ready, Busy, ResultValid, Product, AluA, AluB, AluFunSel, AluWF
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared 32-bit ALU for the
// accumulate (ADD32) and multiplicand shift (LSL32) steps.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                Clock,
  input  logic                ResetN,
  alu_mul_sequencer_if.slave  bus
);

  if (2 * WIDTH > 32) begin : g_width_check
    $error("alu_mul_sequencer: 2*WIDTH must not exceed 32");
  end

  mul_state_e       state_q, state_d;
  logic [31:0]      p_q, p_d;
  logic [31:0]      m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= StIdle;
      p_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      q_q     <= q_d;
    end
  end

  // Next state and Moore output decode; ALU outputs default to the idle pass-through.
  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    m_d           = m_q;
    q_d           = q_q;
    bus.AluA      = '0;
    bus.AluB      = '0;
    bus.AluFunSel = FS_A32;
    bus.AluWF     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.Start) begin
          p_d     = '0;
          m_d     = 32'(bus.MulA);
          q_d     = bus.MulB;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (q_q == '0) begin
          state_d = StDone;
        end else if (q_q[0]) begin
          state_d = StAdd;
        end else begin
          state_d = StShl;
        end
      end
      StAdd: begin
        bus.AluA      = p_q;
        bus.AluB      = m_q;
        bus.AluFunSel = FS_ADD32;
        bus.AluWF     = 1'b1;
        p_d           = bus.AluOut;
        state_d       = StShl;
      end
      StShl: begin
        bus.AluA      = m_q;
        bus.AluFunSel = FS_LSL32;
        m_d           = bus.AluOut;
        q_d           = q_q >> 1;
        state_d       = StCheck;
      end
      StDone: begin
        if (bus.ResultReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.Ready       = (state_q == StIdle);
  assign bus.Busy        = (state_q == StCheck) || (state_q == StAdd) || (state_q == StShl);
  assign bus.ResultValid = (state_q == StDone);
  assign bus.Product     = p_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural ALU model.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int unsigned WIDTH = 16;

  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Reference ALU: A pass, 32-bit add with carry, logical shift left by one.
  logic [32:0] add_sum;
  logic [3:0]  alu_flags = 4'b0;
  logic        carry_seen = 1'b0;

  always_comb begin
    add_sum = {1'b0, bus.AluA} + {1'b0, bus.AluB};
    case (bus.AluFunSel)
      FS_ADD32: bus.AluOut = add_sum[31:0];
      FS_LSL32: bus.AluOut = {bus.AluA[30:0], 1'b0};
      default:  bus.AluOut = bus.AluA;
    endcase
  end

  always @(posedge Clock) begin
    if (bus.AluWF && bus.AluFunSel == FS_ADD32) begin
      alu_flags[FLAG_CARRY] <= add_sum[32];
      alu_flags[FLAG_ZERO]  <= (add_sum[31:0] == 32'h0);
    end
    if (alu_flags[FLAG_CARRY]) carry_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Accept one operand pair and wait for ResultValid; edges counts the accept edge as 1.
  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                output int edges, output int wf_cycles);
    bus.Start = 1'b1;
    bus.MulA  = a;
    bus.MulB  = b;
    tick();
    bus.Start = 1'b0;
    bus.MulA  = 16'hDEAD;
    bus.MulB  = 16'hBEEF;
    edges     = 1;
    wf_cycles = 0;
    while (!bus.ResultValid && edges < 200) begin
      if (bus.AluWF) wf_cycles++;
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_prod, input int exp_edges, input int exp_wf);
    int edges;
    int wf;
    start_and_wait(a, b, edges, wf);
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    check({tag, "_product"}, 32'(bus.Product), exp_prod);
    check({tag, "_wf_cycles"}, 32'(wf), 32'(exp_wf));
    check({tag, "_ready_in_done"}, 32'(bus.Ready), 32'd0);
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
    check({tag, "_back_to_idle"}, 32'(bus.Ready), 32'd1);
  endtask

  initial begin
    bus.Start       = 1'b0;
    bus.MulA        = '0;
    bus.MulB        = '0;
    bus.ResultReady = 1'b0;

    // Reset held for two cycles.
    ResetN = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bus.Ready), 32'd1);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_valid", 32'(bus.ResultValid), 32'd0);
    check("rst_product", 32'(bus.Product), 32'd0);
    check("rst_funsel", 32'(bus.AluFunSel), 32'b10000);
    check("rst_wf", 32'(bus.AluWF), 32'd0);
    check("rst_alua", bus.AluA, 32'd0);
    check("rst_alub", bus.AluB, 32'd0);
    ResetN = 1'b1;
    tick();

    // 3*5: n=3, pop=2 -> 10 edges.
    run_op("mul3x5", 16'd3, 16'd5, 32'd15, 10, 2);
    // Max operands: n=16, pop=16 -> 50 edges, no carry out of any add.
    run_op("mulmax", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 50, 16);
    check("mulmax_carry", 32'(carry_seen), 32'd0);
    // Zero multiplier: straight CHECK -> DONE.
    run_op("mulzero", 16'h1234, 16'h0000, 32'd0, 2, 0);
    // 0x0100 * 0x0300: n=10, pop=2 -> 24 edges.
    run_op("mulsparse", 16'h0100, 16'h0300, 32'h00030000, 24, 2);

    // Backpressure: 7*6=42, n=3, pop=2 -> 10 edges.
    begin
      int edges;
      int wf;
      start_and_wait(16'd7, 16'd6, edges, wf);
      check("bp_latency", 32'(edges), 32'd10);
      for (int i = 0; i < 5; i++) begin
        bus.Start = (i == 2);
        bus.MulA  = 16'd9;
        bus.MulB  = 16'd9;
        tick();
        check("bp_valid_held", 32'(bus.ResultValid), 32'd1);
        check("bp_product_stable", 32'(bus.Product), 32'd42);
      end
      bus.Start       = 1'b1;
      bus.ResultReady = 1'b1;
      tick();
      check("bp_idle_after_ready", 32'(bus.Ready), 32'd1);
      check("bp_start_not_taken", 32'(bus.Busy), 32'd0);
      bus.Start       = 1'b0;
      bus.ResultReady = 1'b0;
      tick();
      check("bp_still_idle", 32'(bus.Ready), 32'd1);
    end

    // Reset while in ADD aborts the operation.
    begin
      int valid_seen;
      bus.Start = 1'b1;
      bus.MulA  = 16'd3;
      bus.MulB  = 16'd5;
      tick();
      bus.Start = 1'b0;
      tick();
      check("abort_in_add", 32'(bus.AluWF), 32'd1);
      ResetN = 1'b0;
      tick();
      ResetN = 1'b1;
      check("abort_ready", 32'(bus.Ready), 32'd1);
      check("abort_wf", 32'(bus.AluWF), 32'd0);
      check("abort_busy", 32'(bus.Busy), 32'd0);
      check("abort_product", 32'(bus.Product), 32'd0);
      valid_seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (bus.ResultValid) valid_seen++;
        tick();
      end
      check("abort_no_result", 32'(valid_seen), 32'd0);
      // 6*7: n=3, pop=3 -> 11 edges.
      run_op("after_abort", 16'd6, 16'd7, 32'd42, 11, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
